// File: rtl/bnn_seq_ctrl_if.sv
// rtl/bnn_seq_ctrl_if.sv - host/datapath signal bundle for the BNN sequencer
interface bnn_seq_ctrl_if;
    logic       start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] x_data;
    logic       x_valid;
    logic       x_ready;
    logic       setup;
    logic       shift_en;
    logic       param_in;
    logic [7:0] bnn_out;
    logic       x_bank_hi;
    logic [3:0] x_nib;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic [7:0] param_crc;

    modport slave (
        input  start, cfg_data, cfg_valid, x_data, x_valid, bnn_out,
        output cfg_ready, x_ready, setup, shift_en, param_in, x_bank_hi, x_nib,
               res_valid, res_data, busy, param_crc
    );

    modport master (
        output start, cfg_data, cfg_valid, x_data, x_valid, bnn_out,
        input  cfg_ready, x_ready, setup, shift_en, param_in, x_bank_hi, x_nib,
               res_valid, res_data, busy, param_crc
    );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// rtl/bnn_seq_ctrl.sv - BNN parameter-chain loader and input/result sequencer
// Optional parameter-stream CRC-8 enabled by defining BNN_SEQ_CRC_EN.
module bnn_seq_ctrl #(
    parameter int PARAM_BITS = 160,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bnn_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_IN_LO, S_IN_HI, S_RESULT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PARAM_BITS - 1);

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       idx_q, idx_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       x_q, x_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;

    logic       load_go;
    logic       cfg_ready_c, x_ready_c, setup_c, shift_en_c, param_in_c;
    logic       x_bank_hi_c, busy_c;
    logic [3:0] x_nib_c;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        full_d      = full_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        load_go     = 1'b0;
        cfg_ready_c = 1'b0;
        x_ready_c   = 1'b0;
        setup_c     = 1'b0;
        shift_en_c  = 1'b0;
        param_in_c  = 1'b0;
        x_bank_hi_c = 1'b0;
        x_nib_c     = 4'h0;
        busy_c      = 1'b0;
        case (state_q)
            S_IDLE: load_go = bus.start;
            S_RUN: begin
                x_ready_c = !bus.start;
                load_go   = bus.start;
                if (!bus.start && bus.x_valid) begin
                    x_d     = bus.x_data;
                    state_d = S_IN_LO;
                end
            end
            S_LOAD: begin
                setup_c    = 1'b1;
                busy_c     = 1'b1;
                shift_en_c = full_q;
                param_in_c = full_q & sr_q[0];
                // The final byte's last bit must not pull in another byte.
                cfg_ready_c = !full_q || (idx_q == 3'd7 && cnt_q != LAST_BIT);
                if (full_q) begin
                    sr_d  = sr_q >> 1;
                    idx_d = idx_q + 3'd1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (idx_q == 3'd7) full_d = 1'b0;
                    if (cnt_q == LAST_BIT) state_d = S_RUN;
                end
                if (cfg_ready_c && bus.cfg_valid) begin
                    sr_d   = bus.cfg_data;
                    idx_d  = 3'd0;
                    full_d = 1'b1;
                end
            end
            S_IN_LO: begin
                busy_c  = 1'b1;
                x_nib_c = x_q[3:0];
                state_d = S_IN_HI;
            end
            S_IN_HI: begin
                busy_c      = 1'b1;
                x_bank_hi_c = 1'b1;
                x_nib_c     = x_q[7:4];
                state_d     = S_RESULT;
            end
            S_RESULT: state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
        if (load_go) begin
            state_d = S_LOAD;
            sr_d    = 8'h00;
            idx_d   = 3'd0;
            full_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // Both banks sit in the datapath input register during RESULT.
    assign res_valid_d = (state_q == S_RESULT);
    assign res_data_d  = (state_q == S_RESULT) ? bus.bnn_out : res_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sr_q        <= 8'h00;
            idx_q       <= 3'd0;
            full_q      <= 1'b0;
            cnt_q       <= '0;
            x_q         <= 8'h00;
            res_data_q  <= 8'h00;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.x_ready   = x_ready_c;
    assign bus.setup     = setup_c;
    assign bus.shift_en  = shift_en_c;
    assign bus.param_in  = param_in_c;
    assign bus.x_bank_hi = x_bank_hi_c;
    assign bus.x_nib     = x_nib_c;
    assign bus.busy      = busy_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

`ifdef BNN_SEQ_CRC_EN
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (load_go)
            crc_d = 8'h00;
        else if (shift_en_c)
            crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ param_in_c) ? 8'h07 : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) crc_q <= 8'h00;
        else        crc_q <= crc_d;
    end

    assign bus.param_crc = crc_q;
`else
    assign bus.param_crc = 8'h00;
`endif
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb/tb_bnn_seq_ctrl.sv - directed self-checking bench for bnn_seq_ctrl
module tb_bnn_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_seq_ctrl_if bus ();

    bnn_seq_ctrl #(.PARAM_BITS(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // Observations gathered by do_load
    int          sh_cnt, first_sh, last_sh, setup_err, gap_shift, acc_cnt;
    logic [15:0] sh_bits;
    logic        setup_after, load_done;
    logic [7:0]  crc_entry;

    // Param stream: 0xA5 then 0x3C, bit 0 first, so shift k carries bit k of this word.
    localparam logic [15:0] EXP_BITS = 16'h3CA5;

    function automatic logic [7:0] crc8_model(input logic [15:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 16; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int gap);
        logic [7:0] bytes [2];
        int   bidx, gap_ctr;
        logic waiting, in_gap, post, acc;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        sh_cnt = 0; first_sh = -1; last_sh = -1; setup_err = 0; gap_shift = 0; acc_cnt = 0;
        sh_bits = 16'h0; setup_after = 1'b1; load_done = 1'b0; crc_entry = 8'hFF;
        bidx = 0; gap_ctr = 0; waiting = 1'b0; in_gap = 1'b0; post = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data = bytes[0];
        for (int cyc = 0; cyc < 60 && !load_done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) crc_entry = bus.param_crc;
            if (post) begin
                setup_after = bus.setup;
                if (bus.shift_en !== 1'b0) sh_cnt++;
                load_done = 1'b1;
            end else begin
                if (bus.setup !== 1'b1) setup_err++;
                if (in_gap && bus.shift_en !== 1'b0) gap_shift++;
                if (bus.shift_en === 1'b1) begin
                    if (sh_cnt < 16) sh_bits[sh_cnt] = bus.param_in;
                    if (first_sh < 0) first_sh = cyc;
                    last_sh = cyc;
                    sh_cnt++;
                    if (sh_cnt == 16) post = 1'b1;
                end
            end
            acc = bus.cfg_valid && bus.cfg_ready;
            tick;
            in_gap = 1'b0;
            if (acc) begin
                acc_cnt++;
                bidx++;
                if (bidx >= 2) bus.cfg_data = 8'hFF;
                else if (gap > 0) begin
                    bus.cfg_valid = 1'b0;
                    waiting = 1'b1;
                end else bus.cfg_data = bytes[bidx];
            end
            if (waiting && sh_cnt >= 8) begin
                if (gap_ctr < gap) begin
                    in_gap = 1'b1;
                    gap_ctr++;
                end else begin
                    bus.cfg_valid = 1'b1;
                    bus.cfg_data = bytes[bidx];
                    waiting = 1'b0;
                end
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [38:0] outs;
        bus.start = 0; bus.cfg_data = 0; bus.cfg_valid = 0; bus.x_data = 0; bus.x_valid = 0; bus.bnn_out = 0;
        rst_n = 1'b0;
        tick; tick;
        @(negedge clk);
        outs = {bus.cfg_ready, bus.x_ready, bus.setup, bus.shift_en, bus.param_in, bus.x_bank_hi,
                bus.x_nib, bus.res_valid, bus.res_data, bus.busy, bus.param_crc, bus.res_data};
        total++; if (outs !== 39'h0) begin bad++; $display("FAIL reset_init outs got=%h want=0", outs); end
        tick;
        rst_n = 1'b1;
        bus.start = 1'b1; tick; bus.start = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'hA5;
        tick; tick; tick;
        @(negedge clk);
        total++; if (bus.shift_en !== 1'b1) begin bad++; $display("FAIL reset_midload_shift got=%b want=1", bus.shift_en); end
        tick;
        rst_n = 1'b0;
        tick; tick;
        @(negedge clk);
        outs = {bus.cfg_ready, bus.x_ready, bus.setup, bus.shift_en, bus.param_in, bus.x_bank_hi,
                bus.x_nib, bus.res_valid, bus.res_data, bus.busy, bus.param_crc, bus.res_data};
        total++; if (outs !== 39'h0) begin bad++; $display("FAIL reset_midload outs got=%h want=0", outs); end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.cfg_ready, bus.setup, bus.busy, bus.x_ready} !== 4'b0000) begin
                bad++; $display("FAIL reset_idle_hold cyc=%0d got=%b want=0000", i,
                                {bus.cfg_ready, bus.setup, bus.busy, bus.x_ready});
            end
            tick;
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_full_load;
        do_load(0);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", load_done); end
        total++; if (sh_cnt != 16) begin bad++; $display("FAIL full_shift_count got=%0d want=16", sh_cnt); end
        total++; if (last_sh - first_sh + 1 != 16) begin bad++; $display("FAIL full_contiguous span got=%0d want=16", last_sh - first_sh + 1); end
        total++; if (sh_bits !== EXP_BITS) begin bad++; $display("FAIL full_param_bits got=%h want=%h", sh_bits, EXP_BITS); end
        total++; if (setup_err != 0) begin bad++; $display("FAIL full_setup_held errs got=%0d want=0", setup_err); end
        total++; if (setup_after !== 1'b0) begin bad++; $display("FAIL full_setup_fall got=%b want=0", setup_after); end
        total++; if (acc_cnt != 2) begin bad++; $display("FAIL full_bytes_taken got=%0d want=2", acc_cnt); end
        @(negedge clk);
        total++; if ({bus.x_ready, bus.cfg_ready, bus.busy} !== 3'b100) begin
            bad++; $display("FAIL full_run_state got=%b want=100", {bus.x_ready, bus.cfg_ready, bus.busy}); end
        tick;
    endtask

    task automatic test_starved_load;
        do_load(3);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL starve_done got=%b want=1", load_done); end
        total++; if (sh_cnt != 16) begin bad++; $display("FAIL starve_shift_count got=%0d want=16", sh_cnt); end
        total++; if (gap_shift != 0) begin bad++; $display("FAIL starve_gap_shift got=%0d want=0", gap_shift); end
        total++; if (setup_err != 0) begin bad++; $display("FAIL starve_setup_held errs got=%0d want=0", setup_err); end
        total++; if (last_sh - first_sh != 19) begin bad++; $display("FAIL starve_span got=%0d want=19", last_sh - first_sh); end
        total++; if (sh_bits !== EXP_BITS) begin bad++; $display("FAIL starve_param_bits got=%h want=%h", sh_bits, EXP_BITS); end
    endtask

    task automatic test_inference;
        bus.bnn_out = 8'h5A; bus.x_data = 8'h9E; bus.x_valid = 1'b1;
        @(negedge clk);
        total++; if (bus.x_ready !== 1'b1) begin bad++; $display("FAIL inf_ready got=%b want=1", bus.x_ready); end
        tick;
        bus.x_valid = 1'b0; bus.x_data = 8'h00;
        @(negedge clk);
        total++; if ({bus.x_bank_hi, bus.x_nib, bus.busy, bus.x_ready} !== 7'b0_1110_1_0) begin
            bad++; $display("FAIL inf_in_lo got=%b want=0111010", {bus.x_bank_hi, bus.x_nib, bus.busy, bus.x_ready}); end
        tick;
        @(negedge clk);
        total++; if ({bus.x_bank_hi, bus.x_nib, bus.busy, bus.x_ready} !== 7'b1_1001_1_0) begin
            bad++; $display("FAIL inf_in_hi got=%b want=1100110", {bus.x_bank_hi, bus.x_nib, bus.busy, bus.x_ready}); end
        tick;
        @(negedge clk);
        total++; if ({bus.x_bank_hi, bus.x_nib, bus.res_valid, bus.x_ready} !== 7'b0) begin
            bad++; $display("FAIL inf_result_state got=%b want=0000000", {bus.x_bank_hi, bus.x_nib, bus.res_valid, bus.x_ready}); end
        tick;
        bus.bnn_out = 8'hC3;
        @(negedge clk);
        total++; if ({bus.res_valid, bus.res_data} !== {1'b1, 8'h5A}) begin
            bad++; $display("FAIL inf_result got=%b/%h want=1/5a", bus.res_valid, bus.res_data); end
        tick;
        @(negedge clk);
        total++; if ({bus.res_valid, bus.res_data} !== {1'b0, 8'h5A}) begin
            bad++; $display("FAIL inf_result_hold got=%b/%h want=0/5a", bus.res_valid, bus.res_data); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] xs [3];
        logic [7:0] exp_res [3];
        int   nacc, nres, nrdy, res_bad;
        xs[0] = 8'h11; xs[1] = 8'h2B; xs[2] = 8'hF0;
        nacc = 0; nres = 0; nrdy = 0; res_bad = 0;
        bus.x_valid = 1'b1; bus.x_data = xs[0];
        for (int c = 0; c < 16; c++) begin
            logic acc;
            @(negedge clk);
            if (c < 12 && bus.x_ready === 1'b1) nrdy++;
            if (bus.res_valid === 1'b1) begin
                if (nres >= nacc || bus.res_data !== exp_res[nres]) res_bad++;
                nres++;
            end
            acc = bus.x_valid && bus.x_ready;
            tick;
            if (acc) begin
                exp_res[nacc] = xs[nacc] ^ 8'hC3;
                bus.bnn_out = exp_res[nacc];
                nacc++;
                if (nacc < 3) bus.x_data = xs[nacc];
                else bus.x_valid = 1'b0;
            end
        end
        bus.x_valid = 1'b0;
        total++; if (nrdy != 3) begin bad++; $display("FAIL b2b_ready_count got=%0d want=3", nrdy); end
        total++; if (nacc != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", nacc); end
        total++; if (nres != 3) begin bad++; $display("FAIL b2b_results got=%0d want=3", nres); end
        total++; if (res_bad != 0) begin bad++; $display("FAIL b2b_res_data errs got=%0d want=0", res_bad); end
    endtask

    task automatic test_priority;
        bus.start = 1'b1; bus.x_valid = 1'b1; bus.x_data = 8'h77;
        @(negedge clk);
        total++; if (bus.x_ready !== 1'b0) begin bad++; $display("FAIL prio_x_ready got=%b want=0", bus.x_ready); end
        tick;
        bus.start = 1'b0; bus.x_valid = 1'b0;
        @(negedge clk);
        total++; if ({bus.setup, bus.busy, bus.x_bank_hi, bus.x_nib, bus.shift_en} !== 8'b1100_0000) begin
            bad++; $display("FAIL prio_load_entered got=%b want=11000000",
                            {bus.setup, bus.busy, bus.x_bank_hi, bus.x_nib, bus.shift_en}); end
        tick;
        do_load(0);
        total++; if (load_done !== 1'b1 || sh_bits !== EXP_BITS) begin
            bad++; $display("FAIL prio_reload got=%b/%h want=1/%h", load_done, sh_bits, EXP_BITS); end
    endtask

    task automatic test_crc;
        logic [7:0] exp_crc;
`ifdef BNN_SEQ_CRC_EN
        exp_crc = crc8_model(EXP_BITS);
`else
        exp_crc = 8'h00;
`endif
        do_load(0);
        total++; if (crc_entry !== 8'h00) begin bad++; $display("FAIL crc_cleared got=%h want=00", crc_entry); end
        @(negedge clk);
        total++; if (bus.param_crc !== exp_crc) begin bad++; $display("FAIL crc_value got=%h want=%h", bus.param_crc, exp_crc); end
        tick; tick;
        @(negedge clk);
        total++; if (bus.param_crc !== exp_crc) begin bad++; $display("FAIL crc_hold got=%h want=%h", bus.param_crc, exp_crc); end
        tick;
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_starved_load;
        test_inference;
        test_back_to_back;
        test_priority;
        test_crc;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
